// File: rtl/ram_master.sv
// ram_master: single/burst bus initiator for the 64x8 scratch RAM.
// Write beats stream straight into the RAM; read beats land in a one-entry
// output register with backpressure.
// Optional build macro RAM_MASTER_BOUND_CHECK_EN: bursts that would run past
// the top address are rejected with a one-cycle err pulse instead of wrapping.
module ram_master #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    // request channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    // write data channel
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    // read data channel
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    // status
    output logic          done,
    output logic          err,
    // RAM pins
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StDrain} state_e;

    localparam logic [AW-1:0] One = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] remain_q, remain_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;

`ifdef RAM_MASTER_BOUND_CHECK_EN
    logic          err_q, err_d;
    logic [AW:0]   end_addr;
    logic          req_oob;

    // One extra bit catches a burst whose last beat lies past the top address.
    assign end_addr = {1'b0, req_addr} + {1'b0, req_len};
    assign req_oob  = end_addr[AW];
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;

    // Next-state, datapath updates and combinational RAM/handshake strobes.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        done_d     = 1'b0;
`ifdef RAM_MASTER_BOUND_CHECK_EN
        err_d      = 1'b0;
`endif
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_a      = '0;
        mem_d      = '0;

        // Consumer drains the output register; a new capture below overrides.
        if (rd_ready) begin
            rd_valid_d = 1'b0;
        end

        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        cur_addr_d = req_addr;
                        remain_d   = req_len;
`ifdef RAM_MASTER_BOUND_CHECK_EN
                        if (req_oob) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = req_write ? StWr : StRd;
                        end
`else
                        state_d = req_write ? StWr : StRd;
`endif
                    end
                end

                StWr: begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        mem_we = 1'b1;
                        mem_a  = cur_addr_q;
                        mem_d  = wr_data;
                        if (remain_q == '0) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            remain_d   = remain_q - One;
                            cur_addr_d = cur_addr_q + One;
                        end
                    end
                end

                StRd: begin
                    // Issue only when the output register is empty or emptying.
                    if (!rd_valid_q || rd_ready) begin
                        mem_re     = 1'b1;
                        mem_a      = cur_addr_q;
                        rd_data_d  = mem_q;
                        rd_valid_d = 1'b1;
                        if (remain_q == '0) begin
                            state_d = StDrain;
                        end else begin
                            remain_d   = remain_q - One;
                            cur_addr_d = cur_addr_q + One;
                        end
                    end
                end

                StDrain: begin
                    if (rd_valid_q && rd_ready) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            remain_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef RAM_MASTER_BOUND_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
`ifdef RAM_MASTER_BOUND_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// Scoreboard bench for ram_master: stimulus pushes expected RAM writes and
// read beats into queues; a negedge monitor pops and compares them.
module tb_ram_master;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_q;

    ram_master #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .err       (err),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    // Behavioural 64x8 RAM: synchronous write, combinational read.
    logic [DW-1:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;
    assign mem_q = mem_re ? ram[mem_a] : '0;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;

    logic [AW+DW-1:0] wr_exp_q [$];
    logic [DW-1:0]    rd_exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every RAM write and every consumed read beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_re) chk("we_re_exclusive", {31'd0, mem_re}, 32'd0);
            if (mem_we) begin
                if (wr_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got a=%0d d=0x%0h expected none", mem_a, mem_d);
                end else begin
                    chk("write_beat", {18'd0, mem_a, mem_d}, {18'd0, wr_exp_q.pop_front()});
                end
            end
            if (rd_valid && rd_ready) begin
                if (rd_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%0h expected none", rd_data);
                end else begin
                    chk("read_beat", {24'd0, rd_data}, {24'd0, rd_exp_q.pop_front()});
                end
            end
            if (done) done_seen++;
            if (err) err_seen++;
        end
    end

    // Present a request (caller is just after a posedge) and wait for acceptance.
    task automatic accept_req(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("req_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] base);
        int beats;
        int cyc;
        for (int i = 0; i <= int'(l); i++) wr_exp_q.push_back({a + AW'(i), base + DW'(i)});
        wr_valid = 1'b1;
        wr_data  = base;
        accept_req(1'b1, a, l);
        beats = 0;
        cyc   = 0;
        while (beats <= int'(l) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wr_ready && wr_valid) beats++;
            @(posedge clk); #1;
            wr_data = base + DW'(beats);
            if (beats > int'(l)) wr_valid = 1'b0;
        end
        chk("write_cycles", cyc, int'(l) + 1);
        @(negedge clk);
        chk("write_done_pulse", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("write_done_once", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] base);
        int beats;
        int cyc;
        for (int i = 0; i <= int'(l); i++) rd_exp_q.push_back(base + DW'(i));
        rd_ready = 1'b1;
        accept_req(1'b0, a, l);
        beats = 0;
        cyc   = 0;
        while (beats <= int'(l) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rd_valid && rd_ready) beats++;
            @(posedge clk); #1;
        end
        chk("read_cycles", cyc, int'(l) + 2);
        @(negedge clk);
        chk("read_done_pulse", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    int exp_done = 0;
    int exp_err = 0;

    initial begin
        // Reset: combinational strobes gated, registers cleared.
        @(negedge clk);
        chk("rst_req_ready_gated", {31'd0, req_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;

        // Write burst 0x05 len 3, then read it back.
        do_write(6'h05, 6'd3, 8'hA1);
        exp_done++;
        do_read(6'h05, 6'd3, 8'hA1);
        exp_done++;

        // Read len 2 with consumer stalled for 3 cycles after the first beat.
        rd_exp_q.push_back(8'hA1);
        rd_exp_q.push_back(8'hA2);
        rd_exp_q.push_back(8'hA3);
        rd_ready = 1'b0;
        accept_req(1'b0, 6'h05, 6'd2);
        @(negedge clk);
        chk("stall_first_issue", {31'd0, mem_re}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold_data", {24'd0, rd_data}, 32'hA1);
            chk("stall_valid", {31'd0, rd_valid}, 32'd1);
            chk("stall_no_re", {31'd0, mem_re}, 32'd0);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 20 && rd_exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("stall_beats_left", rd_exp_q.size(), 32'd0);
        @(negedge clk);
        chk("stall_done_pulse", {31'd0, done}, 32'd1);
        exp_done++;
        @(posedge clk); #1;

`ifdef RAM_MASTER_BOUND_CHECK_EN
        // Out-of-range burst: rejected, err one cycle later, no done.
        wr_valid = 1'b1;
        wr_data  = 8'hB1;
        accept_req(1'b1, 6'd62, 6'd3);
        @(negedge clk);
        chk("oob_err_pulse", {31'd0, err}, 32'd1);
        chk("oob_no_done", {31'd0, done}, 32'd0);
        chk("oob_no_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("oob_err_once", {31'd0, err}, 32'd0);
        chk("oob_back_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        exp_err++;
`else
        // Wrapping burst 62,63,0,1 and its readback.
        do_write(6'd62, 6'd3, 8'hB1);
        exp_done++;
        do_read(6'd62, 6'd3, 8'hB1);
        exp_done++;
`endif

        // Reset during beat 2 of an 8-beat write.
        wr_exp_q.push_back({6'h10, 8'hC0});
        wr_exp_q.push_back({6'h11, 8'hC1});
        wr_valid = 1'b1;
        wr_data  = 8'hC0;
        accept_req(1'b1, 6'h10, 6'd7);
        @(posedge clk); #1;
        wr_data = 8'hC1;
        @(posedge clk); #1;
        rst = 1'b1;
        wr_data = 8'hC2;
        @(negedge clk);
        chk("rst_mid_we_gated", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_no_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_no_re", {31'd0, mem_re}, 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_writes_done", wr_exp_q.size(), 32'd0);
        chk("rst_mid_ram_kept", {24'd0, ram[6'h11]}, 32'hC1);
        chk("rst_mid_ram_untouched", {24'd0, ram[6'h12]}, 32'h00);

        // Back-to-back single-beat writes with req_valid held high.
        wr_exp_q.push_back({6'h20, 8'h55});
        wr_exp_q.push_back({6'h21, 8'h66});
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'h20;
        req_len   = 6'd0;
        wr_valid  = 1'b1;
        wr_data   = 8'h55;
        @(negedge clk);
        chk("b2b_first_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_addr = 6'h21;
        @(negedge clk);
        chk("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
        chk("b2b_first_we", {31'd0, mem_we}, 32'd1);
        @(posedge clk); #1;
        wr_data = 8'h66;
        @(negedge clk);
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        chk("b2b_accept_in_done", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_we", {31'd0, mem_we}, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_done", {31'd0, done}, 32'd1);
        exp_done += 2;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        chk("writes_drained", wr_exp_q.size(), 32'd0);
        chk("reads_drained", rd_exp_q.size(), 32'd0);
        chk("done_total", done_seen, exp_done);
        chk("err_total", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
